// File: rtl/right_shifter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : right_shifter_seq
//  Description : Multi-cycle right shifter (logical or arithmetic), one bit
//                position per clock, valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module right_shifter_seq #(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] C_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] C_ZERO = '0;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [SHW-1:0]   count_q,     count_d;
  logic             arith_q,     arith_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             fill;

  // Bit shifted in at the top: sign copy for arithmetic, zero for logical.
  assign fill = arith_q & shreg_q[WIDTH-1];

  // Next-state logic; handshake outputs are computed one cycle early so they
  // come straight from flops and always match the state register.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    arith_d     = arith_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d    = in_data;
          count_d    = in_shamt;
          arith_d    = in_arith;
          in_ready_d = 1'b0;
          if (in_shamt == C_ZERO) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        shreg_d = {fill, shreg_q[WIDTH-1:1]};
        count_d = count_q - C_ONE;
        if (count_q == C_ONE) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        // Result held until the consumer takes it; the completing edge
        // never accepts a new operand.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      arith_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      arith_q     <= arith_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = shreg_q;

endmodule
`default_nettype wire

// File: tb/tb_right_shifter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_right_shifter_seq
//  Description : Self-checking bench for right_shifter_seq with a
//                behavioural shift model and randomized operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_right_shifter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  right_shifter_seq #(.WIDTH(64), .SHW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [63:0] d, input int n, input logic ar);
    logic signed [63:0] s;
    s = d;
    if (ar) return 64'(s >>> n);
    return d >> n;
  endfunction

  // Issue one operation; returns result, edges from accept to out_valid, timeout flag.
  task automatic run_op(input logic [63:0] d, input logic [5:0] sh, input logic ar,
                        input int stall, output logic [63:0] res, output int lat,
                        output bit to);
    to  = 1'b0;
    lat = 0;
    res = '0;
    for (int i = 0; i < 200 && !in_ready; i++) tick();
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_arith  = ar;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_shamt = 6'($urandom);
    in_arith = 1'($urandom);
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      to = 1'b1;
      return;
    end
    res = out_data;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_logical();
    logic [63:0] r; int lat; bit to;
    run_op(64'h8000_0000_0000_0000, 6'd63, 1'b0, 0, r, lat, to);
    n_checks++; if (to || r !== 64'h1) begin n_fail++; $display("FAIL logical_63: got %h expected %h timeout=%0d", r, 64'h1, to); end
    n_checks++; if (lat !== 63) begin n_fail++; $display("FAIL logical_63_latency: got %0d expected 63", lat); end
  endtask

  task automatic test_arith();
    logic [63:0] r; int lat; bit to;
    run_op(64'h8000_0000_0000_0000, 6'd63, 1'b1, 0, r, lat, to);
    n_checks++; if (to || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL arith_63: got %h expected all-ones", r); end
    run_op(64'h7000_0000_0000_0000, 6'd4, 1'b1, 0, r, lat, to);
    n_checks++; if (to || r !== 64'h0700_0000_0000_0000) begin n_fail++; $display("FAIL arith_pos_4: got %h expected %h", r, 64'h0700_0000_0000_0000); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL arith_pos_4_latency: got %0d expected 4", lat); end
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd17, 1'b1, 0, r, lat, to);
    n_checks++; if (to || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL arith_minus1: got %h expected all-ones", r); end
  endtask

  task automatic test_zero_shift();
    logic [63:0] r; int lat; bit to;
    run_op(64'hDEAD_BEEF_0123_4567, 6'd0, 1'b1, 0, r, lat, to);
    n_checks++; if (to || r !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL zero_shift: got %h expected %h", r, 64'hDEAD_BEEF_0123_4567); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL zero_shift_latency: got %0d extra cycles expected 0", lat); end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    for (int i = 0; i < 200 && !in_ready; i++) tick();
    in_valid = 1'b1; in_data = 64'hF0; in_shamt = 6'd2; in_arith = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    while (!out_valid && guard < 200) begin tick(); guard++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: out_valid got %b expected 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_data !== 64'h3C || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got data=%h valid=%b ready=%b expected data=3c valid=1 ready=0", i, out_data, out_valid, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_shift();
    bit seen = 1'b0;
    in_valid = 1'b1; in_data = 64'h1234_5678_9ABC_DEF0; in_shamt = 6'd10; in_arith = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_mid_shift: got ready=%b valid=%b data=%h expected 1/0/0", in_ready, out_valid, out_data);
    end
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_spurious: got out_valid pulse=%b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    int guard = 0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    for (int i = 0; i < 200 && !in_ready; i++) tick();
    in_valid = 1'b1; in_data = a; in_shamt = 6'd5; in_arith = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    // new request presented during SHIFT and held through the DONE handshake
    in_valid = 1'b1; in_data = b; in_shamt = 6'd1; in_arith = 1'b1;
    while (!out_valid && guard < 200) begin tick(); guard++; end
    n_checks++; if (out_valid !== 1'b1 || out_data !== model(a, 5, 1'b0)) begin
      n_fail++; $display("FAIL ignored_input: got valid=%b data=%h expected 1/%h", out_valid, out_data, model(a, 5, 1'b0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_accept_on_done: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_idle: got ready=%b expected 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== model(b, 1, 1'b1)) begin
      n_fail++; $display("FAIL b2b_second_result: got valid=%b data=%h expected 1/%h", out_valid, out_data, model(b, 1, 1'b1));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] d, r; logic [5:0] sh; logic ar; int lat; bit to;
    for (int k = 0; k < 24; k++) begin
      d  = {$urandom, $urandom};
      sh = (k == 0) ? 6'd63 : 6'($urandom);
      ar = 1'($urandom);
      if (k % 3 == 0) d[63] = 1'b1;
      run_op(d, sh, ar, int'($urandom_range(0, 2)), r, lat, to);
      n_checks++;
      if (to || r !== model(d, int'(sh), ar) || lat !== int'(sh)) begin
        n_fail++;
        $display("FAIL random[%0d] d=%h sh=%0d ar=%b: got %h lat=%0d expected %h lat=%0d timeout=%0d",
                 k, d, sh, ar, r, lat, model(d, int'(sh), ar), sh, to);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete expected within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_zero_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
